// File: rtl/nunchuck_pkg.sv
// Shared types and constants for the nunchuck I2C target emulator.
package nunchuck_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    WR_BYTE,
    WR_ACK,
    RD_BYTE,
    RD_ACK,
    IGNORE
  } state_t;

  localparam logic [6:0] NUNCHUCK_ADDR = 7'h52;
  localparam logic [7:0] INIT_REG_A    = 8'hF0;
  localparam logic [7:0] INIT_VAL_A    = 8'h55;
  localparam logic [7:0] INIT_REG_B    = 8'hFB;
  localparam logic [7:0] INIT_VAL_B    = 8'h00;
  localparam int         FRAME_LEN     = 6;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? 8'hFF : v + 8'd1;
  endfunction

endpackage

// File: rtl/i2c_bus_sync.sv
// Synchronizes raw SCL/SDA into clkin and produces single-cycle edge,
// START and STOP pulses.
module i2c_bus_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clkin,
  input  logic rst,
  input  logic scl,
  input  logic sda_in,
  output logic sda_s,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  logic [SYNC_STAGES-1:0] scl_sr;
  logic [SYNC_STAGES-1:0] sda_sr;
  logic                   scl_d;
  logic                   sda_d;
  logic                   scl_s;

  // Flops reset to the idle-bus level so reset never fakes an edge.
  always_ff @(posedge clkin) begin
    if (!rst) begin
      scl_sr <= '1;
      sda_sr <= '1;
      scl_d  <= 1'b1;
      sda_d  <= 1'b1;
    end else begin
      scl_sr <= {scl_sr[SYNC_STAGES-2:0], scl};
      sda_sr <= {sda_sr[SYNC_STAGES-2:0], sda_in};
      scl_d  <= scl_sr[SYNC_STAGES-1];
      sda_d  <= sda_sr[SYNC_STAGES-1];
    end
  end

  assign scl_s     = scl_sr[SYNC_STAGES-1];
  assign sda_s     = sda_sr[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_d;
  assign scl_fall  = ~scl_s & scl_d;
  assign start_det = scl_s & scl_d & sda_d & ~sda_s;
  assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;

endmodule

// File: rtl/nunchuck_i2c_target.sv
// I2C target emulating an unencrypted Wii Nunchuck for board loopback.
// state    | meaning
// IDLE     | bus free, waiting for START
// ADDR     | shifting in address + R/W
// ADDR_ACK | driving address ACK
// WR_BYTE  | shifting in a write byte
// WR_ACK   | driving write ACK
// RD_BYTE  | driving frame[pointer] MSB first
// RD_ACK   | sampling master ACK/NACK
// IGNORE   | not addressed, waiting for START/STOP
module nunchuck_i2c_target
  import nunchuck_pkg::*;
#(
  parameter logic [6:0] I2C_ADDR    = NUNCHUCK_ADDR,
  parameter int         SYNC_STAGES = 2,
  parameter int         FRAME_LEN   = nunchuck_pkg::FRAME_LEN
) (
  input  logic        clkin,
  input  logic        rst,
  input  logic        scl,
  input  logic        sda_in,
  output logic        sda_oe,
  input  logic [7:0]  stick_x,
  input  logic [7:0]  stick_y,
  input  logic [9:0]  accel_x,
  input  logic [9:0]  accel_y,
  input  logic [9:0]  accel_z,
  input  logic        z,
  input  logic        c,
  output logic        init_done,
  output logic [15:0] frame_count,
  output logic        busy
);

  logic sda_s, scl_rise, scl_fall, start_det, stop_det;

  i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clkin     (clkin),
    .rst       (rst),
    .scl       (scl),
    .sda_in    (sda_in),
    .sda_s     (sda_s),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  state_t      state, state_n;
  logic [3:0]  bit_cnt, bit_cnt_n;
  logic [7:0]  sr, sr_n;
  logic [7:0]  ptr, ptr_n, ptr_inc;
  logic        oe_n, busy_n;
  logic        first_byte, first_n;
  logic        rw, rw_n;
  logic        ack_bit, ack_n;
  logic        flag_a, flag_a_n, flag_b, flag_b_n;
  logic        snap_en, fc_inc;
  logic [47:0] frame_q, snap;
  logic [7:0]  rd_byte, nx_byte;
  logic [2:0]  bit_idx;

  // Byte i lives at frame_q[i*8 +: 8].
  assign snap = {accel_z[1:0], accel_y[1:0], accel_x[1:0], ~c, ~z,
                 accel_z[9:2], accel_y[9:2], accel_x[9:2], stick_y, stick_x};

  function automatic logic [7:0] byte_at(input logic [47:0] f, input logic [7:0] p);
    logic [7:0] b;
    b = 8'hFF;
    for (int i = 0; i < 6; i++)
      if (p == 8'(i) && i < FRAME_LEN) b = f[i*8 +: 8];
    return b;
  endfunction

  assign ptr_inc   = sat_inc(ptr);
  assign rd_byte   = byte_at(frame_q, ptr);
  assign nx_byte   = byte_at(frame_q, ptr_inc);
  assign bit_idx   = 3'd7 - bit_cnt[2:0];
  assign init_done = flag_a & flag_b;

  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    sr_n      = sr;
    oe_n      = sda_oe;
    busy_n    = busy;
    ptr_n     = ptr;
    first_n   = first_byte;
    rw_n      = rw;
    ack_n     = ack_bit;
    flag_a_n  = flag_a;
    flag_b_n  = flag_b;
    snap_en   = 1'b0;
    fc_inc    = 1'b0;
    if (stop_det) begin
      state_n = IDLE;
      oe_n    = 1'b0;
      busy_n  = 1'b0;
    end else if (start_det) begin
      state_n   = ADDR;
      bit_cnt_n = 4'd0;
    end else begin
      case (state)
        ADDR: begin
          if (scl_rise && bit_cnt < 4'd8) begin
            sr_n      = {sr[6:0], sda_s};
            bit_cnt_n = bit_cnt + 4'd1;
          end else if (scl_fall && bit_cnt == 4'd8) begin
            if (sr[7:1] == I2C_ADDR) begin
              state_n = ADDR_ACK;
              oe_n    = 1'b1;
              busy_n  = 1'b1;
              rw_n    = sr[0];
              first_n = 1'b1;
              snap_en = sr[0];
            end else begin
              state_n = IGNORE;
              busy_n  = 1'b0;
            end
          end
        end
        ADDR_ACK: begin
          if (scl_fall) begin
            bit_cnt_n = 4'd0;
            if (rw) begin
              state_n = RD_BYTE;
              oe_n    = ~rd_byte[7];
            end else begin
              state_n = WR_BYTE;
              oe_n    = 1'b0;
            end
          end
        end
        WR_BYTE: begin
          if (scl_rise && bit_cnt < 4'd8) begin
            sr_n      = {sr[6:0], sda_s};
            bit_cnt_n = bit_cnt + 4'd1;
          end else if (scl_fall && bit_cnt == 4'd8) begin
            if (first_byte) begin
              ptr_n   = sr;
              first_n = 1'b0;
            end else begin
              if (ptr == INIT_REG_A && sr == INIT_VAL_A) flag_a_n = 1'b1;
              if (ptr == INIT_REG_B && sr == INIT_VAL_B) flag_b_n = 1'b1;
              ptr_n = ptr_inc;
            end
            state_n = WR_ACK;
            oe_n    = 1'b1;
          end
        end
        WR_ACK: begin
          if (scl_fall) begin
            state_n   = WR_BYTE;
            bit_cnt_n = 4'd0;
            oe_n      = 1'b0;
          end
        end
        RD_BYTE: begin
          if (scl_rise && bit_cnt < 4'd8) begin
            bit_cnt_n = bit_cnt + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt == 4'd8) begin
              state_n = RD_ACK;
              oe_n    = 1'b0;
            end else if (bit_cnt != 4'd0) begin
              oe_n = ~rd_byte[bit_idx];
            end
          end
        end
        RD_ACK: begin
          if (scl_rise) begin
            ack_n  = sda_s;
            fc_inc = (ptr == 8'(FRAME_LEN - 1));
          end else if (scl_fall) begin
            if (!ack_bit) begin
              ptr_n     = ptr_inc;
              state_n   = RD_BYTE;
              bit_cnt_n = 4'd0;
              oe_n      = ~nx_byte[7];
            end else begin
              state_n = IGNORE;
              busy_n  = 1'b0;
              oe_n    = 1'b0;
            end
          end
        end
        IDLE, IGNORE: ;
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clkin) begin
    if (!rst) begin
      state       <= IDLE;
      bit_cnt     <= 4'd0;
      sr          <= 8'd0;
      sda_oe      <= 1'b0;
      busy        <= 1'b0;
      ptr         <= 8'd0;
      first_byte  <= 1'b0;
      rw          <= 1'b0;
      ack_bit     <= 1'b1;
      flag_a      <= 1'b0;
      flag_b      <= 1'b0;
      frame_count <= 16'd0;
      frame_q     <= '1;
    end else begin
      state      <= state_n;
      bit_cnt    <= bit_cnt_n;
      sr         <= sr_n;
      sda_oe     <= oe_n;
      busy       <= busy_n;
      ptr        <= ptr_n;
      first_byte <= first_n;
      rw         <= rw_n;
      ack_bit    <= ack_n;
      flag_a     <= flag_a_n;
      flag_b     <= flag_b_n;
      if (fc_inc) frame_count <= frame_count + 16'd1;
      if (snap_en) frame_q <= snap;
    end
  end

endmodule

// File: tb/tb_nunchuck_i2c_target.sv
// Bench: bit-banged I2C master against the nunchuck target, with a
// scoreboard of expected read bytes and a table of read scenarios.
module tb_nunchuck_i2c_target;

  logic        clkin = 1'b0;
  logic        rst = 1'b0;
  logic        scl = 1'b1;
  logic        sda_m = 1'b1;
  logic        sda_in;
  logic        sda_oe;
  logic [7:0]  stick_x = 8'h00, stick_y = 8'h00;
  logic [9:0]  accel_x = 10'h000, accel_y = 10'h000, accel_z = 10'h000;
  logic        z = 1'b0, c = 1'b0;
  logic        init_done;
  logic [15:0] frame_count;
  logic        busy;

  assign sda_in = sda_m & ~sda_oe;

  nunchuck_i2c_target dut (
    .clkin       (clkin),
    .rst         (rst),
    .scl         (scl),
    .sda_in      (sda_in),
    .sda_oe      (sda_oe),
    .stick_x     (stick_x),
    .stick_y     (stick_y),
    .accel_x     (accel_x),
    .accel_y     (accel_y),
    .accel_z     (accel_z),
    .z           (z),
    .c           (c),
    .init_done   (init_done),
    .frame_count (frame_count),
    .busy        (busy)
  );

  always #10 clkin = ~clkin;

  int checks = 0;
  int errors = 0;
  int fc_exp = 0;
  logic [7:0] exp_q[$];
  logic watch = 1'b0, seen_oe = 1'b0, seen_busy = 1'b0;

  always @(negedge clkin) begin
    if (watch) begin
      if (sda_oe) seen_oe = 1'b1;
      if (busy) seen_busy = 1'b1;
    end
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [7:0]       sx, sy;
    logic [9:0]       ax, ay, az;
    logic             zb, cb;
    logic [7:0]       ptr;
    int               n;
    logic [0:5][7:0]  exp;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wq();
    repeat (10) @(posedge clkin);
    #1;
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; scl = 1'b1; wq();
    sda_m = 1'b0; wq();
    scl = 1'b0; wq();
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wq();
    scl = 1'b1; wq();
    sda_m = 1'b1; wq();
  endtask

  task automatic write_bit(input logic b);
    sda_m = b; wq();
    scl = 1'b1; wq(); wq();
    scl = 1'b0; wq();
  endtask

  task automatic read_bit(output logic b);
    sda_m = 1'b1; wq();
    scl = 1'b1; wq();
    b = sda_in; wq();
    scl = 1'b0; wq();
  endtask

  task automatic write_byte(input logic [7:0] d, input logic exp_ack);
    logic a;
    for (int k = 7; k >= 0; k--) write_bit(d[k]);
    read_bit(a);
    check("ack", 32'(a), 32'(exp_ack));
  endtask

  task automatic read_byte(input logic nack);
    logic [7:0] b;
    logic bv;
    for (int k = 7; k >= 0; k--) begin
      read_bit(bv);
      b[k] = bv;
    end
    write_bit(nack);
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL rd_byte: got %0h expected nothing (scoreboard empty)", b);
    end else begin
      check("rd_byte", 32'(b), 32'(exp_q.pop_front()));
    end
  endtask

  task automatic set_ptr(input logic [7:0] p);
    i2c_start();
    write_byte(8'hA4, 1'b0);
    write_byte(p, 1'b0);
    i2c_stop();
  endtask

  task automatic read_frame(input int n);
    i2c_start();
    write_byte(8'hA5, 1'b0);
    for (int i = 0; i < n; i++) read_byte(i == n - 1);
    i2c_stop();
  endtask

  initial begin
    vecs[0] = '{8'h80, 8'h7F, 10'h200, 10'h1FF, 10'h3C5, 1'b1, 1'b0, 8'h00, 6,
                {8'h80, 8'h7F, 8'h80, 8'h7F, 8'hF1, 8'h72}};
    vecs[1] = '{8'h12, 8'h34, 10'h3FF, 10'h000, 10'h155, 1'b0, 1'b1, 8'h00, 6,
                {8'h12, 8'h34, 8'hFF, 8'h00, 8'h55, 8'h4D}};
    vecs[2] = '{8'hAA, 8'h55, 10'h001, 10'h002, 10'h003, 1'b1, 1'b1, 8'h04, 4,
                {8'h00, 8'hE4, 8'hFF, 8'hFF, 8'h00, 8'h00}};
    vecs[3] = '{8'h01, 8'h02, 10'h2AA, 10'h155, 10'h0F0, 1'b0, 1'b0, 8'h02, 3,
                {8'hAA, 8'h55, 8'h3C, 8'h00, 8'h00, 8'h00}};
    vecs[4] = '{8'h01, 8'h02, 10'h2AA, 10'h155, 10'h0F0, 1'b0, 1'b0, 8'h05, 1,
                {8'h1B, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}};

    // reset state
    repeat (3) @(posedge clkin);
    #1;
    check("rst_sda_oe", 32'(sda_oe), 0);
    check("rst_init_done", 32'(init_done), 0);
    check("rst_frame_count", 32'(frame_count), 0);
    check("rst_busy", 32'(busy), 0);
    rst = 1'b1;
    wq();

    // init sequence
    i2c_start();
    write_byte(8'hA4, 1'b0);
    check("busy_addressed", 32'(busy), 1);
    write_byte(8'hF0, 1'b0);
    write_byte(8'h55, 1'b0);
    i2c_stop();
    check("init_done_half", 32'(init_done), 0);
    check("busy_after_stop", 32'(busy), 0);
    i2c_start();
    write_byte(8'hA4, 1'b0);
    write_byte(8'hFB, 1'b0);
    write_byte(8'h00, 1'b0);
    i2c_stop();
    check("init_done", 32'(init_done), 1);

    // table-driven reads
    for (int v = 0; v < 5; v++) begin
      stick_x = vecs[v].sx; stick_y = vecs[v].sy;
      accel_x = vecs[v].ax; accel_y = vecs[v].ay; accel_z = vecs[v].az;
      z = vecs[v].zb; c = vecs[v].cb;
      for (int i = 0; i < vecs[v].n; i++) begin
        exp_q.push_back(vecs[v].exp[i]);
        if (int'(vecs[v].ptr) + i == 5) fc_exp++;
      end
      set_ptr(vecs[v].ptr);
      read_frame(vecs[v].n);
      check("frame_count", 32'(frame_count), 32'(fc_exp));
      check("busy_idle", 32'(busy), 0);
      check("init_done_sticky", 32'(init_done), 1);
    end

    // foreign address is NACKed and ignored
    watch = 1'b1;
    i2c_start();
    write_byte(8'hA6, 1'b1);
    write_byte(8'h00, 1'b1);
    i2c_stop();
    watch = 1'b0;
    check("foreign_sda_oe", 32'(seen_oe), 0);
    check("foreign_busy", 32'(seen_busy), 0);

    // snapshot holds while inputs change mid-frame
    stick_x = 8'h10; stick_y = 8'h22;
    accel_x = 10'h100; accel_y = 10'h204; accel_z = 10'h30B; z = 1'b0; c = 1'b0;
    set_ptr(8'h00);
    exp_q.push_back(8'h10); exp_q.push_back(8'h22); exp_q.push_back(8'h40);
    exp_q.push_back(8'h81); exp_q.push_back(8'hC2); exp_q.push_back(8'hC3);
    fc_exp++;
    i2c_start();
    write_byte(8'hA5, 1'b0);
    read_byte(1'b0);
    stick_x = 8'h20; c = 1'b1; accel_x = 10'h3FF;
    for (int i = 1; i < 6; i++) read_byte(i == 5);
    i2c_stop();
    check("snap_frame_count", 32'(frame_count), 32'(fc_exp));
    set_ptr(8'h00);
    exp_q.push_back(8'h20);
    read_frame(1);

    // reset while target drives a 0 bit
    stick_x = 8'h00;
    set_ptr(8'h00);
    i2c_start();
    write_byte(8'hA5, 1'b0);
    check("pre_rst_drive", 32'(sda_oe), 1);
    check("pre_rst_busy", 32'(busy), 1);
    @(posedge clkin); #1;
    rst = 1'b0;
    @(posedge clkin); #1;
    check("mid_rst_sda_oe", 32'(sda_oe), 0);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_init_done", 32'(init_done), 0);
    check("mid_rst_frame_count", 32'(frame_count), 0);
    rst = 1'b1;
    wq();
    i2c_stop();
    stick_x = 8'h5A;
    exp_q.push_back(8'h5A);
    read_frame(1);
    check("post_rst_busy", 32'(busy), 0);
    check("scoreboard_drained", 32'(exp_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
